// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises {op,byte} frames for the RAM and serialises read data on MISO.
// Optional protocol-error pulse output enabled by defining SPI_PROTO_ERR_EN.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_PROTO_ERR_EN
  ,
  output logic                 proto_err
`endif
);
  localparam int W   = ADDR_SIZE + 2;
  localparam int CW  = $clog2(W + 1);
  localparam int TCW = $clog2(ADDR_SIZE);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         shreg;
  logic                 rd_addr_done;
  logic                 done;     // this frame's rx_valid already issued
  logic                 wait_tx;
  logic                 tx_act;
  logic [ADDR_SIZE-1:0] tx_sh;
  logic [TCW-1:0]       tx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      rd_addr_done <= 1'b0;
      done         <= 1'b0;
      wait_tx      <= 1'b0;
      tx_act       <= 1'b0;
      tx_sh        <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef SPI_PROTO_ERR_EN
      proto_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_PROTO_ERR_EN
      proto_err <= 1'b0;
`endif
      if (SS_n) begin
        state   <= IDLE;
        cnt     <= '0;
        MISO    <= 1'b0;
        done    <= 1'b0;
        wait_tx <= 1'b0;
        tx_act  <= 1'b0;
`ifdef SPI_PROTO_ERR_EN
        if (state != IDLE && !done) proto_err <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= CHK_CMD;
            cnt   <= '0;
            done  <= 1'b0;
          end
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          default: begin
            if (cnt < CW'(W)) begin
              shreg <= {shreg[W-2:0], MOSI};
              cnt   <= cnt + 1'b1;
            end else if (!done) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              done     <= 1'b1;
              if (state == READ_ADD) rd_addr_done <= 1'b1;
              if (state == READ_DATA) begin
                rd_addr_done <= 1'b0;
                wait_tx      <= 1'b1;
              end
`ifdef SPI_PROTO_ERR_EN
              case (state)
                WRITE:    proto_err <= shreg[W-1];
                READ_ADD: proto_err <= (shreg[W-1:W-2] != 2'b10);
                default:  proto_err <= (shreg[W-1:W-2] != 2'b11);
              endcase
`endif
            end
          end
        endcase

        // read-data serialiser: first bit leaves on the capture edge itself
        if (wait_tx && tx_valid) begin
          wait_tx <= 1'b0;
          tx_act  <= 1'b1;
          MISO    <= tx_data[ADDR_SIZE-1];
          tx_sh   <= tx_data << 1;
          tx_cnt  <= TCW'(ADDR_SIZE - 1);
        end else if (tx_act) begin
          if (tx_cnt != '0) begin
            MISO   <= tx_sh[ADDR_SIZE-1];
            tx_sh  <= tx_sh << 1;
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            MISO   <= 1'b0;
            tx_act <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised frame-level bench for spi_slave_ctrl against a transaction model.
module tb_spi_slave_ctrl;
  localparam int A = 8;
  localparam int W = A + 2;

  logic         clk = 0, rst_n = 0, SS_n = 1, MOSI = 0, tx_valid = 0;
  logic [A-1:0] tx_data = '0;
  logic         MISO, rx_valid;
  logic [W-1:0] rx_data;
`ifdef SPI_PROTO_ERR_EN
  logic         proto_err;
`endif

  spi_slave_ctrl #(.ADDR_SIZE(A)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_PROTO_ERR_EN
    , .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, pulses = 0, perr = 0;
  bit rd_done = 0;
  logic [W-1:0] last_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    pulses += int'(rx_valid);
`ifdef SPI_PROTO_ERR_EN
    perr += int'(proto_err);
`endif
  endtask

  // One frame: select bit, nbits payload bits (nbits<W aborts), then read-data handshake if applicable.
  task automatic send_frame(input bit sel, input logic [W-1:0] word, input int nbits, input logic [A-1:0] byte_v);
    int p0, e0, d, len, exp_perr;
    bit is_rd, is_ra;
    logic [1:0] op;
    logic exp_miso;
    p0 = pulses; e0 = perr;
    is_rd = sel && rd_done;
    is_ra = sel && !rd_done;
    op = word[W-1:W-2];
    SS_n = 0; MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = A'($urandom); tick();
    MOSI = sel; tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[W-1-i]; tick();
    end
    if (nbits < W) begin
      SS_n = 1; tx_valid = 0; tick();
      chk("abort_pulses", pulses - p0, 0);
      chk("abort_rxd_hold", rx_data, last_word);
      chk("abort_miso", MISO, 0);
      exp_perr = 1;
    end else begin
      // garbage tx_valid on the strobe edge must be ignored
      MOSI = 1'($urandom); tx_valid = 1; tx_data = ~byte_v; tick();
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, word);
      last_word = word;
      exp_perr = int'((!sel && op[1]) || (is_ra && op != 2'b10) || (is_rd && op != 2'b11));
      if (is_ra) rd_done = 1;
      if (is_rd) rd_done = 0;
      if (is_rd) begin
        d = $urandom_range(0, 3); len = $urandom_range(1, 9);
        for (int k = 0; k < d + 11; k++) begin
          tx_valid = (k >= d && k < d + len);
          tx_data  = (k == d) ? byte_v : A'($urandom);
          MOSI = 1'($urandom);
          tick();
          exp_miso = (k >= d && k - d < A) ? byte_v[A-1-(k-d)] : 1'b0;
          chk("miso_bit", MISO, exp_miso);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          tx_valid = 1'($urandom); tx_data = A'($urandom); MOSI = 1'($urandom); tick();
          chk("miso_idle", MISO, 0);
        end
      end
      tx_valid = 0;
      SS_n = 1; tick();
      chk("frame_pulses", pulses - p0, 1);
      chk("miso_end", MISO, 0);
    end
`ifdef SPI_PROTO_ERR_EN
    chk("proto_err", perr - e0, exp_perr);
`else
    exp_perr = exp_perr;
`endif
  endtask

  initial begin
    int nb;
    bit s;
    logic [W-1:0] w;
    repeat (3) tick();
    chk("rst_miso", MISO, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    #2 rst_n = 1;
    tick();

    // reset mid-frame right after a strobe; read-address state must be forgotten
    send_frame(1, 10'h2A5, W, 8'h00);
    SS_n = 0; tick();
    MOSI = 0; tick();
    for (int i = 0; i < W; i++) begin
      MOSI = w_bit(10'h0A5, i); tick();
    end
    tick();
    chk("pre_rst_rxv", rx_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_rxv", rx_valid, 0);
    chk("async_rst_rxd", rx_data, 0);
    chk("async_rst_miso", MISO, 0);
    #1 rst_n = 1; SS_n = 1;
    rd_done = 0; last_word = '0;
    pulses = 0; perr = 0;
    tick();
    send_frame(1, 10'h2A5, W, 8'h00);  // must be treated as read-address

    send_frame(0, 10'h0A5, W, 8'h00);
    send_frame(0, 10'h13C, W, 8'h00);
    send_frame(1, 10'h2A5, W, 8'h00);
    send_frame(1, 10'h300, W, 8'h3C);
    send_frame(0, 10'h155, 5, 8'h00);
    send_frame(0, 10'h3C3, W, 8'h00);
    send_frame(1, 10'h2A5, W, 8'h00);
    send_frame(1, 10'h1FF, W, 8'hA5);  // read-data with mismatched op still returns data

    for (int n = 0; n < 40; n++) begin
      s  = 1'($urandom);
      w  = W'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, W - 1) : W;
      send_frame(s, w, nb, A'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  function automatic logic w_bit(input logic [W-1:0] w, input int i);
    return w[W-1-i];
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
